// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP core and its instruction sequencer.
package dsp_pkg;

    localparam int OPCODE_WIDTH        = 6;
    localparam int FIELD_WIDTH         = 10;
    localparam int DEF_INSTR_WIDTH     = OPCODE_WIDTH + 2 * FIELD_WIDTH;
    localparam int DEF_PROG_ADDR_WIDTH = 10;
    localparam int DEF_PIPELINE_DEPTH  = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        NOP    = 6'd0,
        MUL    = 6'd1,
        MAC    = 6'd2,
        ROTMAC = 6'd3,
        STORE  = 6'd4,
        IN     = 6'd5,
        OUT    = 6'd6
    } opcode_t;

    typedef struct packed {
        opcode_t                opcode;
        logic [FIELD_WIDTH-1:0] sample_addr;
        logic [FIELD_WIDTH-1:0] param_addr;
    } instr_t;

    localparam instr_t NOP_INSTR = '{opcode: NOP, sample_addr: '0, param_addr: '0};

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DRAIN
    } seq_state_t;

endpackage

// File: rtl/dsp_sequencer_prog_ram.sv
// Simple dual-port program RAM: one write port, one registered read port.
// The read register can be forced to a fixed value so it doubles as the output stage.
module prog_ram #(
    parameter int                    DATA_WIDTH = 26,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] RD_CLEAR   = '0
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem gives read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= RD_CLEAR;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dsp_sequencer.sv
// Streams the per-sample program from local RAM into the DSP core on each sample tick,
// pads with NOPs while the core pipeline drains, then pulses frame_done.
module dsp_sequencer
    import dsp_pkg::*;
#(
    parameter int INSTR_WIDTH     = DEF_INSTR_WIDTH,
    parameter int PROG_ADDR_WIDTH = DEF_PROG_ADDR_WIDTH,
    parameter int PIPELINE_DEPTH  = DEF_PIPELINE_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic [PROG_ADDR_WIDTH:0]   prog_length,
    input  logic                       prog_wr_en,
    input  logic [PROG_ADDR_WIDTH-1:0] prog_wr_addr,
    input  logic [INSTR_WIDTH-1:0]     prog_wr_data,
    input  logic                       overrun_clear,
    output logic [INSTR_WIDTH-1:0]     instruction,
    output logic                       running,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int DCW = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;
    localparam logic [DCW-1:0]             DRAIN_LOAD = DCW'(PIPELINE_DEPTH - 1);
    localparam logic [DCW-1:0]             DCNT_ONE   = DCW'(1);
    localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE     = PROG_ADDR_WIDTH'(1);
    localparam logic [PROG_ADDR_WIDTH:0]   LEN_ONE    = (PROG_ADDR_WIDTH + 1)'(1);
    localparam logic [PROG_ADDR_WIDTH:0]   MAX_LEN    = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

    seq_state_t                 state;
    logic [PROG_ADDR_WIDTH-1:0] pc;
    logic [PROG_ADDR_WIDTH:0]   n_len;
    logic [PROG_ADDR_WIDTH:0]   tick_len;
    logic [DCW-1:0]             drain_cnt;
    logic                       tick_accept;
    logic                       run_last;
    logic                       fetch;
    logic                       rd_clr;
    logic [PROG_ADDR_WIDTH-1:0] rd_addr;

    // pc is the index of the word on the output; the RAM is read one word ahead so
    // ram[0] is fetched in the tick cycle itself.
    always_comb begin
        tick_len    = (prog_length > MAX_LEN) ? MAX_LEN : prog_length;
        tick_accept = (state == SEQ_IDLE) && sample_tick;
        run_last    = (state == SEQ_RUN) && ({1'b0, pc} == (n_len - LEN_ONE));
        fetch       = (tick_accept && (tick_len != '0)) || ((state == SEQ_RUN) && !run_last);
        rd_addr     = (state == SEQ_RUN) ? (pc + PC_ONE) : '0;
        rd_clr      = reset || !fetch;
    end

    prog_ram #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH (PROG_ADDR_WIDTH),
        .RD_CLEAR   (INSTR_WIDTH'(NOP_INSTR))
    ) u_prog_ram (
        .clk     (clk),
        .wr_en   (prog_wr_en),
        .wr_addr (prog_wr_addr),
        .wr_data (prog_wr_data),
        .rd_clr  (rd_clr),
        .rd_addr (rd_addr),
        .rd_data (instruction)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEQ_IDLE;
            pc         <= '0;
            n_len      <= '0;
            drain_cnt  <= '0;
            running    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A new overrun takes priority over a simultaneous clear.
            if (sample_tick && (state != SEQ_IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
            case (state)
                SEQ_IDLE: begin
                    if (sample_tick) begin
                        n_len   <= tick_len;
                        pc      <= '0;
                        running <= 1'b1;
                        if (tick_len == '0) begin
                            state     <= SEQ_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= SEQ_RUN;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (run_last) begin
                        state     <= SEQ_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        pc <= pc + PC_ONE;
                    end
                end
                SEQ_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state      <= SEQ_IDLE;
                        running    <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DCNT_ONE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer: per-cycle expected outputs are queued when a tick
// is driven and compared at the falling edge of the cycle they belong to.
module tb_dsp_sequencer;
    import dsp_pkg::*;

    localparam int IW    = DEF_INSTR_WIDTH;
    localparam int AW    = DEF_PROG_ADDR_WIDTH;
    localparam int D     = DEF_PIPELINE_DEPTH;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b0;
    logic [AW:0]   prog_length = '0;
    logic          prog_wr_en = 1'b0;
    logic [AW-1:0] prog_wr_addr = '0;
    logic [IW-1:0] prog_wr_data = '0;
    logic          overrun_clear = 1'b0;
    logic [IW-1:0] instruction;
    logic          running;
    logic          frame_done;
    logic          overrun;

    typedef struct {
        int          cyc;
        logic [27:0] val;
    } exp_t;

    exp_t          sb[$];
    logic [IW-1:0] golden [DEPTH];
    logic [IW-1:0] expw   [DEPTH];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    dsp_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .prog_length   (prog_length),
        .prog_wr_en    (prog_wr_en),
        .prog_wr_addr  (prog_wr_addr),
        .prog_wr_data  (prog_wr_data),
        .overrun_clear (overrun_clear),
        .instruction   (instruction),
        .running       (running),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checkOutput($sformatf("out_cyc%0d_at%0d", e.cyc, cyc),
                        {4'b0, instruction, running, frame_done}, {4'b0, e.val});
        end
    end

    function automatic logic [IW-1:0] mk(input opcode_t op, input int s, input int p);
        return {op, 10'(s), 10'(p)};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic tick, input logic clr);
        sample_tick   = tick;
        overrun_clear = clr;
        next_cycle();
        sample_tick   = 1'b0;
        overrun_clear = 1'b0;
    endtask

    task automatic loadWord(input int addr, input logic [IW-1:0] data);
        prog_wr_en   = 1'b1;
        prog_wr_addr = AW'(addr);
        prog_wr_data = data;
        next_cycle();
        prog_wr_en   = 1'b0;
        golden[addr] = data;
    endtask

    task automatic pushExp(input int c, input logic [IW-1:0] ins, input logic run, input logic done);
        exp_t e;
        e.cyc = c;
        e.val = {ins, run, done};
        sb.push_back(e);
    endtask

    // Frame ticked in cycle t with n words: words, D NOPs, frame_done, optional idle tail.
    task automatic expectFrame(input int t, input int n, input bit tail);
        for (int k = 1; k <= n; k++) pushExp(t + k, expw[k-1], 1'b1, 1'b0);
        for (int k = 1; k <= D; k++) pushExp(t + n + k, '0, 1'b1, 1'b0);
        pushExp(t + n + D + 1, '0, 1'b0, 1'b1);
        if (tail) pushExp(t + n + D + 2, '0, 1'b0, 1'b0);
    endtask

    task automatic waitIdle(input int maxc);
        for (int i = 0; i < maxc && sb.size() > 0; i++) next_cycle();
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int t;
        logic [IW-1:0] new5;
        logic [IW-1:0] new9;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_instruction", 32'(instruction), 32'd0);
        checkOutput("reset_running", 32'(running), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);

        // Basic three-word frame
        loadWord(0, mk(MUL, 3, 7));
        loadWord(1, mk(MAC, 4, 8));
        loadWord(2, mk(STORE, 5, 0));
        expw = golden;
        prog_length = 3;
        t = cyc;
        expectFrame(t, 3, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitIdle(50);
        checkOutput("basic_overrun", 32'(overrun), 32'd0);

        // Empty program
        prog_length = 0;
        t = cyc;
        expectFrame(t, 0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitIdle(50);

        // Overrun: busy tick at T+2, then clear, then clear together with a busy tick
        prog_length = 3;
        t = cyc;
        expectFrame(t, 3, 1'b1);
        applyStimulus(1'b1, 1'b0);
        next_cycle();
        checkOutput("ovr_before", 32'(overrun), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovr_set", 32'(overrun), 32'd1);
        waitIdle(50);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ovr_clear", 32'(overrun), 32'd0);
        t = cyc;
        expectFrame(t, 3, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ovr_set_wins", 32'(overrun), 32'd1);
        waitIdle(50);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ovr_clear2", 32'(overrun), 32'd0);

        // Back-to-back: second tick lands in the frame_done cycle
        t = cyc;
        expectFrame(t, 3, 1'b0);
        expectFrame(t + 3 + D + 1, 3, 1'b1);
        applyStimulus(1'b1, 1'b0);
        repeat (3 + D) next_cycle();
        applyStimulus(1'b1, 1'b0);
        checkOutput("b2b_overrun", 32'(overrun), 32'd0);
        waitIdle(50);
        checkOutput("b2b_overrun_end", 32'(overrun), 32'd0);

        // Reset mid-frame aborts without frame_done and clears overrun
        t = cyc;
        pushExp(t + 1, expw[0], 1'b1, 1'b0);
        pushExp(t + 2, expw[1], 1'b1, 1'b0);
        for (int k = 3; k <= 10; k++) pushExp(t + k, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovr_pre_reset", 32'(overrun), 32'd1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        checkOutput("ovr_after_reset", 32'(overrun), 32'd0);
        waitIdle(50);
        t = cyc;
        expectFrame(t, 3, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitIdle(50);

        // Full program, length clamp, read-before-write and in-frame update
        for (int a = 0; a < DEPTH; a++) loadWord(a, IW'($urandom));
        new5 = ~golden[5];
        new9 = ~golden[9];
        expw = golden;
        expw[9] = new9;
        prog_length = 2000;
        t = cyc;
        expectFrame(t, DEPTH, 1'b1);
        applyStimulus(1'b1, 1'b0);
        next_cycle();
        next_cycle();
        loadWord(9, new9);
        next_cycle();
        loadWord(5, new5);
        waitIdle(1200);

        // Replay a short prefix: addr 5 now holds the word written during the frame
        expw = golden;
        prog_length = 6;
        t = cyc;
        expectFrame(t, 6, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitIdle(50);
        checkOutput("final_overrun", 32'(overrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_sequencer.md
# dsp_sequencer

Instruction sequencer sitting directly upstream of the DSP core: holds the per-sample DSP program in a local instruction RAM and, on each audio sample tick, streams the program into the core's `instruction` input one word per clock. It then pads with NOPs until the core pipeline has drained and pulses `frame_done`. It also flags sample ticks that arrive before the previous frame has finished.

## Interface
- `INSTR_WIDTH`, 26: instruction word width (opcode 6 + sample addr 10 + param addr 10).
- `PROG_ADDR_WIDTH`, 10: program RAM address width; depth is 2^PROG_ADDR_WIDTH.
- `PIPELINE_DEPTH`, 4: core cycles from instruction presentation to writeback; sets the drain length D.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high reset.
- `sample_tick` in 1: one-cycle pulse per audio sample; starts a frame.
- `prog_length` in PROG_ADDR_WIDTH+1: number of instructions N in the program. Latched on an accepted tick.
- `prog_wr_en` in 1: program RAM write strobe.
- `prog_wr_addr` in PROG_ADDR_WIDTH: program RAM write address.
- `prog_wr_data` in INSTR_WIDTH: program RAM write data.
- `overrun_clear` in 1: clears the sticky `overrun` flag.
- `instruction` out INSTR_WIDTH: registered instruction to the core.
- `running` out 1: high while in RUN or DRAIN.
- `frame_done` out 1: one-cycle pulse when a frame has fully written back.
- `overrun` out 1: sticky flag; a tick arrived while the sequencer was busy.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - `instruction` = NOP (all zeros).
  - On `sample_tick`, latch N = min(`prog_length`, 2^PROG_ADDR_WIDTH) and set pc = 0.
  - Go to RUN, or go directly to DRAIN if N = 0.
- **RUN**
  - Present ram[pc] and increment pc.
  - After ram[N-1] has been presented, go to DRAIN.
- **DRAIN**
  - Present NOP for D = PIPELINE_DEPTH cycles (down-counter).
  - Then pulse `frame_done` for one cycle and return to IDLE.
- **Overrun**
  - A `sample_tick` while in RUN or DRAIN is ignored and sets `overrun`.
  - `overrun` stays set until `overrun_clear`.
  - If `overrun_clear` and a new overrun occur in the same cycle, set wins.
- **Program RAM writes**
  - Accepted in any state.
  - A same-cycle read and write to one address returns the old data (read-before-write).
  - A write to an address not yet streamed in the current frame takes effect in this frame.
  - RAM contents are not cleared by reset.
- `prog_length` changes take effect only at the next accepted tick.

## Timing
- Definition: a tick is accepted at the clock edge ending cycle T.
- Cycle T+k, k = 1..N:
  - `instruction` = ram[k-1].
  - `running` = 1.
- Cycles T+N+1 .. T+N+D: `instruction` = NOP, `running` = 1.
- Cycle T+N+D+1:
  - `frame_done` = 1, `running` = 0, `instruction` = NOP.
  - A tick in this cycle is accepted without overrun.
- Minimum tick period without overrun: N+D+1 cycles.
- `overrun` rises in the cycle after the offending tick.
- **Reset** (sampled at clk edge), from the next cycle:
  - `instruction` = 0, `running` = 0, `frame_done` = 0, `overrun` = 0.
  - State = IDLE, pc = 0, drain counter = 0.
  - Reset mid-frame aborts the frame and no `frame_done` is issued.
- N = 2^PROG_ADDR_WIDTH:
  - pc wraps to 0 after the last address; the wrapped value is unused because the FSM leaves RUN.
  - pc is PROG_ADDR_WIDTH+1 bits, or the terminal compare uses N-1, so the wrap does not alias.

## Structure
- Shared `dsp_pkg` holds:
  - `opcode_t` (NOP=0, MUL=1, MAC=2, ROTMAC=3, STORE=4, IN=5, OUT=6).
  - `instr_t` packed struct {opcode, sample_addr, param_addr}.
  - Width constants.
  - A `NOP_INSTR` constant.
  - The sequencer state enum.
- Sub-module `prog_ram`: simple dual-port RAM (one write port, one synchronous read port), read-before-write, no reset. Infers block RAM.

## Test plan
1. **Basic frame:** reset; load ram[0..2] = {MUL,3,7}, {MAC,4,8}, {STORE,5,0}; N = 3; tick at T → those words at T+1..T+3, NOP at T+4..T+7, `frame_done` at T+8 only, `running` high T+1..T+7.
2. **Empty program:** N = 0, tick at T → NOP throughout, `running` high T+1..T+4, `frame_done` at T+5.
3. **Overrun:**
   - Tick at T+2 during case 1 → `overrun` = 1 from T+3; stream and `frame_done` timing unchanged.
   - `overrun_clear` → `overrun` = 0.
   - `overrun_clear` together with a new busy tick → `overrun` stays 1.
4. **Back-to-back frames:** tick in the `frame_done` cycle → accepted, ram[0] at the next cycle, `overrun` = 0.
5. **Reset mid-frame:** reset at T+2 → next cycle `instruction` = 0, `running` = 0, no `frame_done`; a later tick replays the retained RAM contents identically.
6. **Full program and writes:**
   - N = 1024: `frame_done` at T+1029.
   - `prog_length` = 2000 clamps to 1024.
   - A write to addr 5 in the same cycle it is read → old word streamed.
   - A write to addr 9 at T+3 → new word streamed at T+10.
